seq_mult16: RTL and testbench
=============================

SEQ_MULT16 -- requirements
Module: seq_mult16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; the product is 2*WIDTH bits wide.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands A/B are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-006 The block SHALL have port A, input, WIDTH bits: unsigned multiplicand.
REQ-007 The block SHALL have port B, input, WIDTH bits: unsigned multiplier.
REQ-008 The block SHALL have port out_valid, output, 1 bit: P holds a completed product.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes P this cycle.
REQ-010 The block SHALL have port P, output, 2*WIDTH bits: product A*B.

Function
REQ-011 The block SHALL implement the three-state FSM IDLE, RUN and DONE.
REQ-012 in_ready SHALL equal (state==IDLE), and out_valid SHALL equal (state==DONE); both are decoded from registered state only, with no combinational path from in_valid or out_ready.
REQ-013 Input handshake (in_valid && in_ready at a clock edge) SHALL do the following at that edge: latch A into a WIDTH-bit multiplicand register; load the product register with upper half = 0 and lower half = B; clear the iteration counter; move to RUN.
REQ-014 Each RUN cycle SHALL perform one shift-add iteration: if product[0]==1, {carry, sum} = upper + multiplicand using a WIDTH-bit add with carry-out, else {carry, sum} = {0, upper}; then product <= {carry, sum, product[WIDTH-1:1]}; then counter increments.
REQ-015 The adder SHALL be exactly WIDTH bits plus carry-out, with carry-in = 0; the carry-out SHALL be kept as the MSB of the shifted product and never dropped.
REQ-016 The block SHALL perform exactly WIDTH iterations; on the edge that completes iteration WIDTH the FSM SHALL move to DONE.
REQ-017 Latency SHALL be exactly WIDTH cycles from the input-handshake edge to the first cycle with out_valid=1 (16 cycles for the default WIDTH).
REQ-018 In DONE, P and out_valid SHALL hold stable until out_ready=1 at a clock edge, after which the FSM SHALL return to IDLE.
REQ-019 P SHALL be driven from the product register at all times; P is meaningful only while out_valid=1.
REQ-020 While in RUN or DONE, in_valid SHALL be ignored (in_ready=0), and A/B changes SHALL have no effect on the computation in progress.
REQ-021 out_ready asserted in IDLE or RUN SHALL have no effect.
REQ-022 Back-to-back operation: after the DONE->IDLE edge, new operands SHALL be accepted on the next edge; sustained throughput is one product per WIDTH+2 cycles.
REQ-023 Boundary conditions SHALL give exact results: A=0 or B=0 gives P=0; A=B=2^WIDTH-1 gives P=(2^WIDTH-1)^2 with no overflow.
REQ-024 The counter SHALL be wide enough to hold WIDTH (5 bits for the default) and SHALL NOT wrap before iteration WIDTH completes.

Reset
REQ-025 When rst_n=0 at a clock edge, the block SHALL, regardless of state: set state=IDLE, clear the product register and multiplicand register to 0, and clear the counter to 0.
REQ-026 After reset the outputs SHALL be in_ready=1, out_valid=0 and P=0.
REQ-027 Reset mid-RUN or mid-DONE SHALL abandon the operation with no out_valid pulse; the first edge with rst_n=1 and in_valid=1 SHALL accept new operands normally.
REQ-028 The block SHALL have no asynchronous reset path; rst_n is sampled only on the rising edge of clk.

Verification
REQ-029 The bench SHALL cover basic multiply: A=0x0003, B=0x0005, handshake at edge k -> out_valid first high after edge k+16, P=0x0000000F, in_ready=0 for edges k+1..k+17.
REQ-030 The bench SHALL cover the maximum operands: A=0xFFFF, B=0xFFFF -> P=0xFFFE0001, carry-out preserved.
REQ-031 The bench SHALL cover backpressure: A=0x1234, B=0x5678, out_ready held 0 for 10 cycles in DONE -> P=0x06260060 stable and out_valid=1 throughout; IDLE one edge after out_ready=1.
REQ-032 The bench SHALL cover ignored inputs: in_valid=1 with A=0xFFFF held continuously during RUN of A=0x0002, B=0x0007 -> P=0x0000000E, with no second acceptance before DONE->IDLE.
REQ-033 The bench SHALL cover reset mid-operation: rst_n=0 for one edge at iteration 8 -> next cycle in_ready=1, out_valid=0, P=0; a subsequent 0x0000*0xABCD gives P=0.
REQ-034 The bench SHALL cover a random sweep: 512 random A/B pairs with out_ready randomly toggled, each P compared against the 32-bit A*B reference; every case SHALL report PASS.

Source files
------------

// File: rtl/seq_mult16_if.sv
// Operand/product handshake bundle for the sequential shift-add multiplier.
// The producer/consumer side uses master; the multiplier uses slave.
interface seq_mult16_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   P;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, P
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, P
  );
endinterface

// File: rtl/seq_mult16.sv
// Unsigned WIDTH x WIDTH sequential multiplier: one shift-add step per cycle,
// WIDTH cycles per product, valid/ready handshakes on both sides.
module seq_mult16 #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_mult16_if.slave  bus
);
  // Counter must be able to hold WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     mcand_reg, mcand_next;
  logic [2*WIDTH-1:0]   prod_reg, prod_next;
  logic [CW-1:0]        cnt_reg, cnt_next;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic                 last_iter;

  // The multiplier LSB gates the multiplicand into the adder.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & prod_reg[0];
    end
  endgenerate

  // WIDTH-bit add with carry-out kept as bit WIDTH; no carry-in.
  assign sum       = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  always_comb begin
    state_next = state_reg;
    mcand_next = mcand_reg;
    prod_next  = prod_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_next = bus.A;
          prod_next  = {{WIDTH{1'b0}}, bus.B};
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        prod_next = {sum, prod_reg[WIDTH-1:1]};
        cnt_next  = cnt_reg + 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mcand_reg <= '0;
      prod_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mcand_reg <= mcand_next;
      prod_reg  <= prod_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Handshake outputs decode registered state only.
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.P         = prod_reg;
endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: directed vector table, reset-in-flight
// sequence and a randomized sweep against a plain A*B reference.
module tb_seq_mult16;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   n_txn;

  seq_mult16_if #(.WIDTH(W)) bus ();

  seq_mult16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    int             hold;
    bit             noise;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction: handshake, wait for result, drain with out_ready.
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp_p, input int hold,
                         input bit noise, input bit rnd, input string tag);
    int             cyc;
    int             busy_rdy;
    int             unstable;
    int             bad0;
    bit             fire;
    logic [2*W-1:0] p_first;
    bad0 = n_bad;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    check({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = noise;
    if (noise) begin
      bus.A = '1;
      bus.B = W'($urandom);
    end
    cyc      = 0;
    busy_rdy = 0;
    while (!bus.out_valid && cyc < 64) begin
      if (bus.in_ready) busy_rdy++;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      if (noise) bus.B = W'($urandom);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(W));
    check({tag, "_product"}, 64'(bus.P), 64'(exp_p));
    p_first  = bus.P;
    unstable = 0;
    for (int i = 0; i < 64; i++) begin
      fire = rnd ? (($urandom_range(0, 1) == 1) || i >= 40) : (i >= hold);
      bus.out_ready = fire;
      if (bus.in_ready) busy_rdy++;
      @(posedge clk); #1;
      if (fire) break;
      if (!bus.out_valid || bus.P !== p_first) unstable++;
    end
    bus.out_ready = 1'b0;
    check({tag, "_busy_in_ready"}, 64'(busy_rdy), 64'd0);
    check({tag, "_done_stable"}, 64'(unstable), 64'd0);
    check({tag, "_back_idle"}, {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
    n_txn++;
    $display("txn %0d %s A=%h B=%h P=%h exp=%h lat=%0d %s",
             n_txn, tag, a, b, p_first, exp_p, cyc, (n_bad == bad0) ? "PASS" : "BAD");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int             pulses;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [2*W-1:0] ref_p;

    n_cmp = 0;
    n_bad = 0;
    n_txn = 0;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 0,  1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0,  1'b0};
    vecs[2] = '{16'h1234, 16'h5678, 32'h06260060, 10, 1'b0};
    vecs[3] = '{16'h0002, 16'h0007, 32'h0000000E, 0,  1'b1};
    vecs[4] = '{16'h0000, 16'hABCD, 32'h00000000, 0,  1'b0};
    vecs[5] = '{16'hABCD, 16'h0000, 32'h00000000, 2,  1'b0};
    vecs[6] = '{16'h0001, 16'hFFFF, 32'h0000FFFF, 0,  1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 32'h40000000, 1,  1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_p", 64'(bus.P), 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_mult(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].hold, vecs[i].noise,
              1'b0, $sformatf("vec%0d", i));
    end

    // Reset lands on the edge of iteration 8 of an in-flight product.
    bus.A        = 16'hABCD;
    bus.B        = 16'h1234;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_p", 64'(bus.P), 64'd0);
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulses++;
    end
    check("midrst_no_pulse", 64'(pulses), 64'd0);
    do_mult(16'h0000, 16'hABCD, 32'h0, 0, 1'b0, 1'b0, "after_rst");

    for (int i = 0; i < 512; i++) begin
      ra    = W'($urandom);
      rb    = W'($urandom);
      ref_p = (2*W)'(ra) * (2*W)'(rb);
      do_mult(ra, rb, ref_p, 0, 1'b0, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
